// File: rtl/mem_arbiter.sv
// Two-master memory port arbiter: instruction fetch (IF) and load/store (DM) share one valid/ready port.
// Define MEM_ARB_FAIRNESS_EN to bound how many back-to-back DM grants may pass a waiting IF request.
module mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_done,
   input  logic                  dm_req,
   input  logic                  dm_write,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   input  logic [2:0]            dm_length,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_done,
   output logic                  mem_valid,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [2:0]            mem_length,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM, RESP} state_t;

   state_t state;
   logic   grant_if;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   logic [SW-1:0] streak;

   // IF overrides DM priority once DM has won MAX_DATA_STREAK grants in a row over it
   assign grant_if = if_req && (!dm_req || (streak == SW'(MAX_DATA_STREAK)));

   always_ff @(posedge clk) begin
      if (reset)
         streak <= '0;
      else if (state == IDLE) begin
         if (grant_if)
            streak <= '0;
         else if (dm_req)
            streak <= if_req ? streak + SW'(1) : '0;
      end
   end
`else
   assign grant_if = if_req && !dm_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         if_rdata   <= '0;
         if_done    <= 1'b0;
         dm_rdata   <= '0;
         dm_done    <= 1'b0;
         mem_valid  <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_length <= '0;
      end else begin
         case (state)
            IDLE: begin
               if_done <= 1'b0;
               dm_done <= 1'b0;
               if (grant_if) begin
                  state      <= GNT_IF;
                  mem_valid  <= 1'b1;
                  mem_write  <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  mem_length <= 3'b010;
               end else if (dm_req) begin
                  state      <= GNT_DM;
                  mem_valid  <= 1'b1;
                  mem_write  <= dm_write;
                  mem_addr   <= dm_addr;
                  mem_wdata  <= dm_wdata;
                  mem_length <= dm_length;
               end
            end
            GNT_IF: begin
               if (mem_ready) begin
                  state     <= RESP;
                  mem_valid <= 1'b0;
                  if_done   <= 1'b1;
                  if_rdata  <= mem_rdata;
               end
            end
            GNT_DM: begin
               if (mem_ready) begin
                  state     <= RESP;
                  mem_valid <= 1'b0;
                  dm_done   <= 1'b1;
                  // stores leave the last load result visible
                  if (!mem_write)
                     dm_rdata <= mem_rdata;
               end
            end
            RESP: begin
               state   <= IDLE;
               if_done <= 1'b0;
               dm_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants and done events are queued at stimulus time
// and consumed by a memory responder model and a done monitor.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_write, mem_ready;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [2:0]  dm_length;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_done, dm_done, mem_valid, mem_write;
   logic [2:0]  mem_length;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  len;
      logic [31:0] rdata;
   } gnt_t;

   typedef struct {
      logic        is_dm;
      logic [31:0] rdata;
   } done_t;

   gnt_t  gnt_q[$];
   done_t done_q[$];
   gnt_t  cur;
   int    n_chk = 0, n_err = 0;
   int    cyc = 0, wait_cnt = 0, mem_lat = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_length(dm_length), .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_length(mem_length), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_gnt(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] len, input logic [31:0] rdata);
      gnt_t g;
      g.wr = wr; g.addr = addr; g.wdata = wdata; g.len = len; g.rdata = rdata;
      gnt_q.push_back(g);
   endtask

   task automatic push_done(input logic is_dm, input logic [31:0] rdata);
      done_t d;
      d.is_dm = is_dm; d.rdata = rdata;
      done_q.push_back(d);
   endtask

   task automatic wait_done(input logic is_dm);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = is_dm ? dm_done : if_done;
      end
      if (!seen) chk(is_dm ? "timeout_dm_done" : "timeout_if_done", 32'd0, 32'd1);
   endtask

   // Memory responder: checks each new grant against the scoreboard, answers after mem_lat cycles
   always @(negedge clk) begin
      if (reset || !mem_valid) begin
         mem_ready = 1'b0;
         wait_cnt  = 0;
         mem_rdata = $urandom;
      end else begin
         if (wait_cnt == 0) begin
            if (gnt_q.size() == 0) begin
               chk("gnt_unexpected", 32'd1, 32'd0);
               cur.wr = 1'b0; cur.addr = '0; cur.wdata = '0; cur.len = '0; cur.rdata = '0;
            end else
               cur = gnt_q.pop_front();
            chk("gnt_addr", mem_addr, cur.addr);
            chk("gnt_write", {31'd0, mem_write}, {31'd0, cur.wr});
            chk("gnt_len", {29'd0, mem_length}, {29'd0, cur.len});
            if (cur.wr) chk("gnt_wdata", mem_wdata, cur.wdata);
         end
         if (wait_cnt >= mem_lat) begin
            chk("hold_addr", mem_addr, cur.addr);
            mem_ready = 1'b1;
            mem_rdata = cur.rdata;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
         wait_cnt++;
      end
   end

   // Done monitor
   always @(negedge clk) begin
      done_t d;
      if (!reset && (if_done || dm_done)) begin
         chk("done_excl", {31'd0, if_done & dm_done}, 32'd0);
         chk("resp_valid_low", {31'd0, mem_valid}, 32'd0);
         if (done_q.size() == 0)
            chk("done_unexpected", 32'd1, 32'd0);
         else begin
            d = done_q.pop_front();
            chk("done_owner", {31'd0, dm_done}, {31'd0, d.is_dm});
            chk(d.is_dm ? "dm_rdata" : "if_rdata", d.is_dm ? dm_rdata : if_rdata, d.rdata);
         end
      end
   end

   initial begin
      int t0, n_dm, n_if, n_dm_max;
      logic fair;
      reset = 1'b1; if_req = 0; dm_req = 0; dm_write = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_length = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_done", {30'd0, if_done, dm_done}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // IF only, memory answers two cycles after mem_valid
      mem_lat = 2;
      push_gnt(1'b0, 32'h100, 32'h0, 3'b010, 32'h0050_0093);
      push_done(1'b0, 32'h0050_0093);
      if_addr = 32'h100; if_req = 1'b1;
      wait_done(1'b0);
      if_req = 1'b0;
      @(negedge clk);

      // Load with mem_ready high immediately: done two cycles after the request
      mem_lat = 0;
      push_gnt(1'b0, 32'h40, 32'h0, 3'b100, 32'h0000_00FF);
      push_done(1'b1, 32'h0000_00FF);
      dm_write = 1'b0; dm_addr = 32'h40; dm_length = 3'b100; dm_req = 1'b1;
      t0 = cyc;
      wait_done(1'b1);
      chk("load_latency", 32'(cyc - t0), 32'd2);
      dm_req = 1'b0;
      @(negedge clk);

      // Simultaneous requests: store first, IF afterwards; store keeps old dm_rdata
      mem_lat = 1;
      push_gnt(1'b1, 32'h2000, 32'hDEAD_BEEF, 3'b010, 32'h1234_5678);
      push_gnt(1'b0, 32'h104, 32'h0, 3'b010, 32'h00A0_0113);
      push_done(1'b1, 32'h0000_00FF);
      push_done(1'b0, 32'h00A0_0113);
      dm_write = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF; dm_length = 3'b010;
      if_addr = 32'h104;
      dm_req = 1'b1; if_req = 1'b1;
      wait_done(1'b1);
      dm_req = 1'b0;
      wait_done(1'b0);
      if_req = 1'b0;
      @(negedge clk);

      // Reset during a stalled DM grant: abandoned, then reissued
      mem_lat = 1000;
      push_gnt(1'b0, 32'h3000, 32'h0, 3'b000, 32'hCAFE_F00D);
      push_gnt(1'b0, 32'h3000, 32'h0, 3'b000, 32'hCAFE_F00D);
      push_done(1'b1, 32'hCAFE_F00D);
      dm_write = 1'b0; dm_addr = 32'h3000; dm_length = 3'b000; dm_req = 1'b1;
      repeat (3) @(negedge clk);
      chk("stall_valid", {31'd0, mem_valid}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst2_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst2_done", {30'd0, if_done, dm_done}, 32'd0);
      chk("rst2_addr", mem_addr, 32'd0);
      chk("rst2_len", {29'd0, mem_length}, 32'd0);
      chk("rst2_rdata", dm_rdata, 32'd0);
      mem_lat = 1;
      reset = 1'b0;
      wait_done(1'b1);
      dm_req = 1'b0;
      @(negedge clk);

      // Both held high: grant order depends on the fairness build
`ifdef MEM_ARB_FAIRNESS_EN
      fair = 1'b1; n_dm_max = 5;
`else
      fair = 1'b0; n_dm_max = 6;
`endif
      mem_lat = 0;
      for (int k = 0; k < n_dm_max; k++) begin
         if (fair && k == 4) begin
            push_gnt(1'b0, 32'h200, 32'h0, 3'b010, 32'h0BAD_C0DE);
            push_done(1'b0, 32'h0BAD_C0DE);
         end
         push_gnt(1'b0, 32'h5000 + 32'(4 * k), 32'h0, 3'b010, 32'h100 + 32'(k));
         push_done(1'b1, 32'h100 + 32'(k));
      end
      if (!fair) begin
         push_gnt(1'b0, 32'h200, 32'h0, 3'b010, 32'h0BAD_C0DE);
         push_done(1'b0, 32'h0BAD_C0DE);
      end
      dm_write = 1'b0; dm_length = 3'b010; dm_addr = 32'h5000; if_addr = 32'h200;
      dm_req = 1'b1; if_req = 1'b1;
      n_dm = 0; n_if = 0;
      for (int c = 0; c < 400 && !(n_dm == n_dm_max && n_if == 1); c++) begin
         @(negedge clk);
         if (dm_done) begin
            n_dm++;
            if (n_dm == n_dm_max) dm_req = 1'b0;
            else dm_addr = 32'h5000 + 32'(4 * n_dm);
         end
         if (if_done) begin
            n_if++;
            if_req = 1'b0;
         end
      end
      chk("streak_dm_count", 32'(n_dm), 32'(n_dm_max));
      chk("streak_if_count", 32'(n_if), 32'd1);
      repeat (3) @(negedge clk);

      chk("gnt_q_left", 32'(gnt_q.size()), 32'd0);
      chk("done_q_left", 32'(done_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
